// File: rtl/udp_rxq_pkg.sv
// -----------------------------------------------------------------------------
// udp_rxq_pkg
// Shared definitions for the UDP receive-queue arbiter and its round-robin
// selector.
//
// Contents:
//   ST_IDLE/ST_XFER/ST_FLUSH : arbiter state encodings
//   state_t                  : arbiter state type built on those encodings
//   CNT_W                    : width of the stall and drop counters
//   sat_inc()                : saturating increment for CNT_W-bit counters
// -----------------------------------------------------------------------------
package udp_rxq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        XFER  = ST_XFER,
        FLUSH = ST_FLUSH
    } state_t;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/udp_rxq_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. It searches the request vector upward
// from the port after i_last_grant, wrapping modulo NPORTS, and returns the
// first requester it finds. Nothing in it is specific to the receive path, so
// it can also be used by a transmit-side arbiter.
//
// Parameters:
//   NPORTS : number of requesters (2..8)
//   PORT_W : width of a port index, clog2(NPORTS)
//
// Ports:
//   i_req        in  NPORTS  request vector
//   i_last_grant in  PORT_W  most recently serviced port
//   o_onehot     out NPORTS  one-hot selection (all zero when no request)
//   o_idx        out PORT_W  index of the selection (zero when no request)
//   o_any        out 1       at least one request is present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NPORTS = 4,
    parameter int PORT_W = 2
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [PORT_W-1:0] i_last_grant,
    output logic [NPORTS-1:0] o_onehot,
    output logic [PORT_W-1:0] o_idx,
    output logic              o_any
);

    // Try candidates last+1, last+2, ... last+NPORTS. The final candidate is
    // last_grant itself, so a lone requester can win twice in a row. Once
    // o_any is set, later candidates are ignored and the first hit stays.
    always_comb begin
        logic [PORT_W-1:0] w_cand;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            w_cand = PORT_W'((int'(i_last_grant) + k) % NPORTS);
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_rxq_arb.sv
// -----------------------------------------------------------------------------
// udp_rxq_arb
// Packet-granular round-robin arbiter. NPORTS validated-packet receive queues
// share one downstream UDP payload consumer through this block. A queue is
// granted in IDLE. Its whole packet is then streamed to the consumer with a
// ready/valid handshake. There is one idle cycle between packets.
//
// Optional feature (macro UDP_RXQ_ARB_TIMEOUT_EN):
//   A packet that stalls for TIMEOUT_CYCLES consecutive non-ready cycles is
//   flushed from its queue. Each flush pulses out_drop and increments
//   drop_count. Without the macro, XFER waits indefinitely and out_drop and
//   drop_count are tied to 0.
//
// Parameters:
//   NPORTS         : number of queues (2..8)
//   PORT_W         : port index width, clog2(NPORTS)
//   TIMEOUT_CYCLES : stall limit before a flush (optional feature only)
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_pkt_avail  : per-queue "complete packet at head"
//   in_d          : per-queue show-ahead head octet, queue i at [8i+7:8i]
//   in_last       : per-queue "head octet ends the packet"
//   in_rdreq      : per-queue pop strobe
//   out_ready     : consumer accepts an octet this cycle
//   out_d         : octet to the consumer
//   out_dv        : out_d transferred this cycle
//   out_last      : transferred octet ends the packet
//   out_port      : granted queue, stable for the whole packet
//   out_drop      : one-cycle pulse when a packet is flushed
//   drop_count    : saturating count of flushed packets
// -----------------------------------------------------------------------------
module udp_rxq_arb
    import udp_rxq_pkg::*;
#(
    parameter int NPORTS         = 4,
    parameter int PORT_W         = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORTS-1:0]     in_pkt_avail,
    input  logic [NPORTS*8-1:0]   in_d,
    input  logic [NPORTS-1:0]     in_last,
    output logic [NPORTS-1:0]     in_rdreq,
    input  logic                  out_ready,
    output logic [7:0]            out_d,
    output logic                  out_dv,
    output logic                  out_last,
    output logic [PORT_W-1:0]     out_port,
    output logic                  out_drop,
    output logic [CNT_W-1:0]      drop_count
);

    state_t              r_state;
    logic [PORT_W-1:0]   r_grant;
    logic [NPORTS-1:0]   r_grant_oh;
    logic [PORT_W-1:0]   r_last_grant;
    logic [PORT_W-1:0]   r_port;

    logic [NPORTS-1:0]   w_pick_oh;
    logic [PORT_W-1:0]   w_pick_idx;
    logic                w_pick_any;

    logic [7:0]          w_head_d;
    logic                w_head_last;
    logic                w_xfer;
    logic                w_flush;

    rr_pick #(
        .NPORTS (NPORTS),
        .PORT_W (PORT_W)
    ) u_rr_pick (
        .i_req        (in_pkt_avail),
        .i_last_grant (r_last_grant),
        .o_onehot     (w_pick_oh),
        .o_idx        (w_pick_idx),
        .o_any        (w_pick_any)
    );

    // Head of the granted queue. The mux is driven from the grant register,
    // so it holds steady for the whole packet.
    assign w_head_d    = in_d[{r_grant, 3'b000} +: 8];
    assign w_head_last = in_last[r_grant];
    assign w_xfer      = (r_state == XFER);

    assign out_d    = w_xfer ? w_head_d : 8'h00;
    assign out_dv   = w_xfer & out_ready;
    assign out_last = w_xfer & out_ready & w_head_last;
    assign out_port = r_port;

    // Only the granted queue may see a pop. It sees one on each accepted
    // transfer, and on every FLUSH cycle.
    assign in_rdreq = r_grant_oh & {NPORTS{(w_xfer & out_ready) | w_flush}};

`ifdef UDP_RXQ_ARB_TIMEOUT_EN

    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_flush    = (r_state == FLUSH);
    assign out_drop   = w_flush & w_head_last;
    assign drop_count = r_drop_cnt;

    // Arbiter FSM with stall timeout. The stall counter counts consecutive
    // non-ready XFER cycles. When it reaches TIMEOUT_CYCLES-1, that cycle is
    // the final stall cycle and the FSM moves to FLUSH. FLUSH then drains the
    // rest of the packet without presenting it to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_oh   <= '0;
            r_last_grant <= PORT_W'(NPORTS - 1);
            r_port       <= '0;
            r_stall      <= '0;
            r_drop_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        r_port     <= w_pick_idx;
                        r_stall    <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (out_ready) begin
                        r_stall <= '0;
                        if (w_head_last) begin
                            r_last_grant <= r_grant;
                            r_state      <= IDLE;
                        end
                    end else if (r_stall == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= FLUSH;
                    end else begin
                        r_stall <= r_stall + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (w_head_last) begin
                        r_drop_cnt   <= sat_inc(r_drop_cnt);
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`else

    logic w_unused_timeout;

    assign w_flush          = 1'b0;
    assign out_drop         = 1'b0;
    assign drop_count       = '0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);

    // Arbiter FSM without timeout. A granted packet holds the consumer until
    // its last octet is accepted, however long the stall lasts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_oh   <= '0;
            r_last_grant <= PORT_W'(NPORTS - 1);
            r_port       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        r_port     <= w_pick_idx;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (out_ready && w_head_last) begin
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_udp_rxq_arb.sv
// -----------------------------------------------------------------------------
// tb_udp_rxq_arb
// Directed, table-driven bench for udp_rxq_arb with NPORTS=4. Each vector
// gives what the queues present for one cycle, together with the outputs
// expected in that cycle. Hand-written sequences follow the table. They cover
// the mid-packet reset and the long stall. The long-stall sequence checks a
// flush when UDP_RXQ_ARB_TIMEOUT_EN is defined, and a plain wait otherwise.
// -----------------------------------------------------------------------------
module tb_udp_rxq_arb;

    localparam int NPORTS = 4;
    localparam int PORT_W = 2;

    logic                clk;
    logic                rst_n;
    logic [NPORTS-1:0]   in_pkt_avail;
    logic [NPORTS*8-1:0] in_d;
    logic [NPORTS-1:0]   in_last;
    logic [NPORTS-1:0]   in_rdreq;
    logic                out_ready;
    logic [7:0]          out_d;
    logic                out_dv;
    logic                out_last;
    logic [PORT_W-1:0]   out_port;
    logic                out_drop;
    logic [15:0]         drop_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          doReset;
        logic [3:0]  avail;
        logic [31:0] d;
        logic [3:0]  last;
        logic        ready;
        logic        expDv;
        logic [7:0]  expD;
        logic        expLast;
        logic [1:0]  expPort;
        logic [3:0]  expRd;
    } vec_t;

    vec_t vecs[$];

    udp_rxq_arb #(
        .NPORTS         (NPORTS),
        .PORT_W         (PORT_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_pkt_avail (in_pkt_avail),
        .in_d         (in_d),
        .in_last      (in_last),
        .in_rdreq     (in_rdreq),
        .out_ready    (out_ready),
        .out_d        (out_d),
        .out_dv       (out_dv),
        .out_last     (out_last),
        .out_port     (out_port),
        .out_drop     (out_drop),
        .drop_count   (drop_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison. A mismatch prints a FAIL line and is counted.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compares every consumer-side output and the pop vector.
    task automatic checkOutput(input string tag, input logic edv, input logic [7:0] ed,
                               input logic elast, input logic [1:0] eport, input logic [3:0] erd);
        checkVal({tag, ".out_dv"},   32'(out_dv),   32'(edv));
        checkVal({tag, ".out_d"},    32'(out_d),    32'(ed));
        checkVal({tag, ".out_last"}, 32'(out_last), 32'(elast));
        checkVal({tag, ".out_port"}, 32'(out_port), 32'(eport));
        checkVal({tag, ".in_rdreq"}, 32'(in_rdreq), 32'(erd));
        checkVal({tag, ".out_drop"}, 32'(out_drop), 32'(1'b0));
    endtask

    // Holds reset across a rising edge and releases it on a falling edge.
    task automatic applyReset();
        rst_n        = 1'b0;
        in_pkt_avail = '0;
        in_d         = '0;
        in_last      = '0;
        out_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle of queue-side inputs.
    task automatic applyStimulus(input logic [3:0] avail, input logic [31:0] d,
                                 input logic [3:0] last, input logic ready);
        in_pkt_avail = avail;
        in_d         = d;
        in_last      = last;
        out_ready    = ready;
    endtask

    task automatic addVec(input bit rst, input logic [3:0] avail, input logic [31:0] d,
                          input logic [3:0] last, input logic ready, input logic edv,
                          input logic [7:0] ed, input logic elast, input logic [1:0] eport,
                          input logic [3:0] erd);
        vec_t v;
        v.doReset = rst;   v.avail = avail; v.d = d;   v.last = last; v.ready = ready;
        v.expDv   = edv;   v.expD  = ed;    v.expLast = elast;
        v.expPort = eport; v.expRd = erd;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_pkt_avail = '0;
        in_d         = '0;
        in_last      = '0;
        out_ready    = 1'b0;

        // Single packet on port 2: 11, 22, 33.
        addVec(1, 4'b0100, 32'h00110000, 4'b0000, 1, 0, 8'h00, 0, 2'd0, 4'b0000);
        addVec(0, 4'b0100, 32'h00110000, 4'b0000, 1, 1, 8'h11, 0, 2'd2, 4'b0100);
        addVec(0, 4'b0100, 32'h00220000, 4'b0000, 1, 1, 8'h22, 0, 2'd2, 4'b0100);
        addVec(0, 4'b0100, 32'h00330000, 4'b0100, 1, 1, 8'h33, 1, 2'd2, 4'b0100);
        addVec(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 2'd2, 4'b0000);
        // All four ports hold 2-octet packets and are serviced 0,1,2,3.
        addVec(1, 4'b1111, 32'hA3A2A1A0, 4'b0000, 1, 0, 8'h00, 0, 2'd0, 4'b0000);
        addVec(0, 4'b1111, 32'hA3A2A1A0, 4'b0000, 1, 1, 8'hA0, 0, 2'd0, 4'b0001);
        addVec(0, 4'b1111, 32'hA3A2A1B0, 4'b0001, 1, 1, 8'hB0, 1, 2'd0, 4'b0001);
        addVec(0, 4'b1110, 32'hA3A2A100, 4'b0000, 1, 0, 8'h00, 0, 2'd0, 4'b0000);
        addVec(0, 4'b1110, 32'hA3A2A100, 4'b0000, 1, 1, 8'hA1, 0, 2'd1, 4'b0010);
        addVec(0, 4'b1110, 32'hA3A2B100, 4'b0010, 1, 1, 8'hB1, 1, 2'd1, 4'b0010);
        addVec(0, 4'b1100, 32'hA3A20000, 4'b0000, 1, 0, 8'h00, 0, 2'd1, 4'b0000);
        addVec(0, 4'b1100, 32'hA3A20000, 4'b0000, 1, 1, 8'hA2, 0, 2'd2, 4'b0100);
        addVec(0, 4'b1100, 32'hA3B20000, 4'b0100, 1, 1, 8'hB2, 1, 2'd2, 4'b0100);
        addVec(0, 4'b1000, 32'hA3000000, 4'b0000, 1, 0, 8'h00, 0, 2'd2, 4'b0000);
        addVec(0, 4'b1000, 32'hA3000000, 4'b0000, 1, 1, 8'hA3, 0, 2'd3, 4'b1000);
        addVec(0, 4'b1000, 32'hB3000000, 4'b1000, 1, 1, 8'hB3, 1, 2'd3, 4'b1000);
        addVec(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 2'd3, 4'b0000);
        // Wrap: last grant 3, ports 0 and 3 request single-octet packets.
        addVec(0, 4'b1001, 32'hC30000C0, 4'b1001, 1, 0, 8'h00, 0, 2'd3, 4'b0000);
        addVec(0, 4'b1001, 32'hC30000C0, 4'b1001, 1, 1, 8'hC0, 1, 2'd0, 4'b0001);
        addVec(0, 4'b1000, 32'hC3000000, 4'b1000, 1, 0, 8'h00, 0, 2'd0, 4'b0000);
        addVec(0, 4'b1000, 32'hC3000000, 4'b1000, 1, 1, 8'hC3, 1, 2'd3, 4'b1000);
        // Back-to-back packet from the same port still takes one idle cycle.
        addVec(0, 4'b1000, 32'hD3000000, 4'b1000, 1, 0, 8'h00, 0, 2'd3, 4'b0000);
        addVec(0, 4'b1000, 32'hD3000000, 4'b1000, 1, 1, 8'hD3, 1, 2'd3, 4'b1000);
        addVec(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 2'd3, 4'b0000);
        // Backpressure on port 1: ready pattern 1,0,0,1,1.
        addVec(0, 4'b0010, 32'h0000E100, 4'b0000, 1, 0, 8'h00, 0, 2'd3, 4'b0000);
        addVec(0, 4'b0010, 32'h0000E100, 4'b0000, 1, 1, 8'hE1, 0, 2'd1, 4'b0010);
        addVec(0, 4'b0000, 32'h0000E200, 4'b0000, 0, 0, 8'hE2, 0, 2'd1, 4'b0000);
        addVec(0, 4'b0000, 32'h0000E200, 4'b0000, 0, 0, 8'hE2, 0, 2'd1, 4'b0000);
        addVec(0, 4'b0000, 32'h0000E200, 4'b0000, 1, 1, 8'hE2, 0, 2'd1, 4'b0010);
        addVec(0, 4'b0000, 32'h0000E300, 4'b0010, 1, 1, 8'hE3, 1, 2'd1, 4'b0010);
        addVec(0, 4'b0000, 32'h00000000, 4'b0000, 1, 0, 8'h00, 0, 2'd1, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) applyReset();
            else @(negedge clk);
            applyStimulus(vecs[i].avail, vecs[i].d, vecs[i].last, vecs[i].ready);
            #2;
            checkOutput($sformatf("vec%0d", i), vecs[i].expDv, vecs[i].expD,
                        vecs[i].expLast, vecs[i].expPort, vecs[i].expRd);
        end

        // Mid-packet reset. Last grant is 1, so ports 0 and 2 together pick 2.
        // After reset the same requests must pick port 0.
        @(negedge clk);
        applyStimulus(4'b0101, 32'h00F200F0, 4'b0000, 1);
        #2 checkOutput("rst.idle", 0, 8'h00, 0, 2'd1, 4'b0000);
        @(negedge clk);
        #2 checkOutput("rst.first", 1, 8'hF2, 0, 2'd2, 4'b0100);
        @(negedge clk);
        applyStimulus(4'b0101, 32'h00F300F0, 4'b0000, 1);
        rst_n = 1'b0;
        #1 checkOutput("rst.async", 0, 8'h00, 0, 2'd0, 4'b0000);
        checkVal("rst.drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0101, 32'h00F200F0, 4'b0000, 1);
        #2 checkOutput("rst.idle2", 0, 8'h00, 0, 2'd0, 4'b0000);
        @(negedge clk);
        #2 checkOutput("rst.regrant", 1, 8'hF0, 0, 2'd0, 4'b0001);

        // Long stall on a 5-octet packet from port 1 (51..55).
        applyReset();
        applyStimulus(4'b0010, 32'h00005100, 4'b0000, 0);
        #2 checkOutput("stall.idle", 0, 8'h00, 0, 2'd0, 4'b0000);
`ifdef UDP_RXQ_ARB_TIMEOUT_EN
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            applyStimulus(4'b0000, 32'h00005100, 4'b0000, 0);
            #2 checkOutput($sformatf("stall%0d", s), 0, 8'h51, 0, 2'd1, 4'b0000);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            applyStimulus(4'b0000, 32'(8'h51 + k) << 8, (k == 4) ? 4'b0010 : 4'b0000, 0);
            #2;
            checkVal($sformatf("flush%0d.in_rdreq", k), 32'(in_rdreq), 32'h2);
            checkVal($sformatf("flush%0d.out_dv", k),   32'(out_dv),   32'd0);
            checkVal($sformatf("flush%0d.out_last", k), 32'(out_last), 32'd0);
            checkVal($sformatf("flush%0d.out_drop", k), 32'(out_drop), (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        applyStimulus(4'b0000, 32'h0, 4'b0000, 0);
        #2 checkOutput("flush.idle", 0, 8'h00, 0, 2'd1, 4'b0000);
        checkVal("flush.drop_count", 32'(drop_count), 32'd1);
`else
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            applyStimulus(4'b0000, 32'h00005100, 4'b0000, 0);
            #2 checkOutput($sformatf("stall%0d", s), 0, 8'h51, 0, 2'd1, 4'b0000);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            applyStimulus(4'b0000, 32'(8'h51 + k) << 8, (k == 4) ? 4'b0010 : 4'b0000, 1);
            #2 checkOutput($sformatf("drain%0d", k), 1, 8'(8'h51 + k), (k == 4), 2'd1, 4'b0010);
        end
        @(negedge clk);
        applyStimulus(4'b0000, 32'h0, 4'b0000, 0);
        #2 checkOutput("drain.idle", 0, 8'h00, 0, 2'd1, 4'b0000);
        checkVal("drain.drop_count", 32'(drop_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_rxq_arb.md
Name: udp_rxq_arb

Overview:
- Packet-granular round-robin arbiter that shares one downstream UDP payload consumer (register/command decoder) between NPORTS validated-packet receive queues.
- Each queue holds only complete, FCS/header-checked packets and exposes a show-ahead octet head with a pop strobe.
- The block grants one queue at a time and streams that whole packet to the consumer with a ready/valid handshake.
- Sits between the per-port receive queues and the single payload consumer.

Parameters:
- NPORTS, 4, number of requesting queues (2..8).
- PORT_W, 2, width of the port index; must equal clog2(NPORTS).
- TIMEOUT_CYCLES, 4096, stall limit before a packet is flushed (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_pkt_avail  in  NPORTS  bit i: queue i has at least one complete packet at its head.
- in_d  in  NPORTS*8  show-ahead head octet; queue i uses bits [8i+7:8i].
- in_last  in  NPORTS  head octet of queue i is the last octet of its packet.
- in_rdreq  out  NPORTS  pop one octet from queue i.
- out_ready  in  1  consumer accepts an octet this cycle.
- out_d  out  8  octet to the consumer.
- out_dv  out  1  out_d is valid and is transferred this cycle.
- out_last  out  1  the transferred octet ends the packet.
- out_port  out  PORT_W  index of the granted queue; stable for the whole packet.
- out_drop  out  1  one-cycle pulse when a packet is flushed (optional feature).
- drop_count  out  16  saturating count of flushed packets (optional feature).

Behaviour:
- Reset: state=IDLE, grant=0, last_grant=NPORTS-1 (so port 0 wins first), out_port=0, counters=0. All strobes are 0: out_dv, out_last, in_rdreq, out_drop.
- States: IDLE, XFER, FLUSH. FLUSH exists only with the optional feature.
- IDLE:
  - If any in_pkt_avail bit is set, select the first set bit searching upward from last_grant+1, wrapping modulo NPORTS.
  - Register the selection into grant and out_port; go to XFER next cycle.
  - No outputs are active in IDLE.
- XFER:
  - out_d = in_d[grant] (combinational mux from the grant register).
  - out_dv = out_ready. in_rdreq[grant] = out_ready. All other in_rdreq bits are 0.
  - out_last = out_ready & in_last[grant].
  - On a cycle with out_ready & in_last[grant]: last_grant<=grant, go to IDLE.
- Timing:
  - Latency from in_pkt_avail rising (registered in IDLE) to the first possible out_dv is 1 cycle.
  - There is exactly one idle cycle between packets, even for back-to-back packets from the same port.
- in_pkt_avail is ignored outside IDLE. Deassertion mid-packet has no effect.
- A single-octet packet (in_last set on the first octet) completes in one XFER transfer cycle.
- out_ready may toggle arbitrarily. Stall cycles hold the grant and produce no pops.
- Asynchronous reset mid-packet: returns to IDLE. Upstream queues must be reset in the same domain event; no partial-packet recovery is attempted.
- Fairness: with all ports requesting continuously, grant order is 0,1,..,NPORTS-1,0,…

Optional Feature:
- Macro: UDP_RXQ_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit stall counter clears on entry to XFER and on every out_ready cycle.
  - It increments on XFER cycles with out_ready=0.
  - When it reaches TIMEOUT_CYCLES-1, go to FLUSH.
  - FLUSH: in_rdreq[grant]=1 every cycle; out_dv=0 and out_last=0.
  - On the cycle with in_last[grant]=1: pulse out_drop, increment drop_count (saturating at 16'hFFFF), last_grant<=grant, go to IDLE.
- Disabled: no stall counter and no FLUSH state. XFER waits indefinitely. out_drop and drop_count are tied to 0.

Decomposition:
- Shared package (udp_rxq_pkg) holds:
  - the state encoding localparams: IDLE=2'd0, XFER=2'd1, FLUSH=2'd2;
  - the 16-bit counter width constant.
- One natural sub-module, rr_pick: combinational round-robin selector. It takes the request vector and last_grant, and returns a one-hot/index result plus an any-request flag. It is reusable by the transmit-side arbiter.

Test Plan:
- Reset then single packet: port 2 holds 3 octets 0x11,0x22,0x33 with in_last on 0x33, out_ready=1. Required: grant 1 cycle after avail; out_d 0x11,0x22,0x33 on consecutive cycles; out_last on the third; out_port=2 throughout.
- All 4 ports hold 2-octet packets, out_ready=1. Required: ports serviced in order 0,1,2,3; one idle cycle between packets; no in_rdreq on non-granted ports.
- Backpressure: out_ready pattern 1,0,0,1,1 on a 3-octet packet. Required: no pop and no out_dv during the 0 cycles; data order is preserved.
- Wrap fairness: last grant=3, ports 0 and 3 both requesting. Required: port 0 is granted next, then port 3.
- Mid-packet reset: assert rst_n=0 after 1 octet of a 4-octet packet. Required: all outputs 0 immediately; IDLE; next grant goes to port 0.
- With UDP_RXQ_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: hold out_ready=0 on a 5-octet packet. Required: FLUSH after 8 stall cycles; 5 pops with out_dv=0; one out_drop pulse; drop_count=1.
